multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 126 ++++++++++++
 tb/tb_multicycle_alu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Bit-serial-by-slice ALU: captures operands in IDLE, processes SLICE bits per
// cycle in RUN with a registered inter-slice carry, and presents result/flags in DONE.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    CMD_ADD, CMD_SUB, CMD_XOR, CMD_SLT, CMD_AND, CMD_NAND, CMD_NOR, CMD_OR
  } cmd_t;

  state_t           state;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [KW-1:0]    k;
  logic             carry;

  logic [SLICE-1:0] sa, sb, sbe, sres;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] acc_nxt, fres;
  logic             inv, is_addsub, last, msb_cin, ovf;

  always_comb begin
    inv       = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    is_addsub = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    sa        = a_q[k*SLICE +: SLICE];
    sb        = b_q[k*SLICE +: SLICE];
    sbe       = inv ? ~sb : sb;
    sum       = {1'b0, sa} + {1'b0, sbe} + {{SLICE{1'b0}}, carry};
    case (cmd_q)
      CMD_XOR:  sres = sa ^ sb;
      CMD_AND:  sres = sa & sb;
      CMD_NAND: sres = ~(sa & sb);
      CMD_NOR:  sres = ~(sa | sb);
      CMD_OR:   sres = sa | sb;
      default:  sres = sum[SLICE-1:0];
    endcase
    // Carry into the slice MSB recovered from its sum bit; only meaningful on the last slice.
    msb_cin = sa[SLICE-1] ^ sbe[SLICE-1] ^ sum[SLICE-1];
    ovf     = msb_cin ^ sum[SLICE];
    last    = (k == KW'(N - 1));
    acc_nxt = acc;
    acc_nxt[k*SLICE +: SLICE] = sres;
    fres = acc_nxt;
    if (cmd_q == CMD_SLT) begin
      fres    = '0;
      fres[0] = acc_nxt[WIDTH-1] ^ ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      cmd_q     <= CMD_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      k         <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= operandA;
            b_q      <= operandB;
            cmd_q    <= cmd_t'(command);
            k        <= '0;
            carry    <= (cmd_t'(command) == CMD_SUB) || (cmd_t'(command) == CMD_SLT);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= sum[SLICE];
          k     <= k + 1'b1;
          if (last) begin
            result    <= fres;
            carryout  <= is_addsub & sum[SLICE];
            overflow  <= is_addsub & ovf;
            zero      <= ~|fres;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Checks multicycle_alu at SLICE=8, 1 and 32 against a plain-arithmetic model,
// with hand-computed vectors pinning the model.
module tb_multicycle_alu;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a, b, res;
    logic        c, o, z;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        c, o, z;
  } exp_t;

  logic        clk, rst_n, in_valid, out_ready;
  logic [31:0] operandA, operandB;
  logic [2:0]  command;
  logic [2:0]  rdy, vld, cf, of, zf;
  logic [31:0] res [3];

  int vectors = 0;
  int miscompares = 0;
  int lat [3] = '{4, 32, 1};
  int wcnt [3];
  logic [2:0] pending = '0;
  logic [2:0] seen = '0;
  logic rst_seen = 1'b0;
  exp_t expv;
  vec_t vecs [14];

  multicycle_alu #(.WIDTH(32), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .operandA(operandA), .operandB(operandB), .command(command),
    .out_valid(vld[0]), .out_ready(out_ready), .result(res[0]),
    .carryout(cf[0]), .overflow(of[0]), .zero(zf[0]));

  multicycle_alu #(.WIDTH(32), .SLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .operandA(operandA), .operandB(operandB), .command(command),
    .out_valid(vld[1]), .out_ready(out_ready), .result(res[1]),
    .carryout(cf[1]), .overflow(of[1]), .zero(zf[1]));

  multicycle_alu #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .operandA(operandA), .operandB(operandB), .command(command),
    .out_valid(vld[2]), .out_ready(out_ready), .result(res[2]),
    .carryout(cf[2]), .overflow(of[2]), .zero(zf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_seen = rst_n;

  function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    e = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.o = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      3'd1: begin
        e.res = a - b;
        e.c = (a >= b);
        e.o = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      3'd2: e.res = a ^ b;
      3'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: e.res = a & b;
      3'd5: e.res = ~(a & b);
      3'd6: e.res = ~(a | b);
      default: e.res = a | b;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, i, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_seen) begin
        chk("rst_in_ready", i, 32'(rdy[i]), 32'd1);
        chk("rst_out_valid", i, 32'(vld[i]), 32'd0);
        chk("rst_result", i, res[i], 32'd0);
        chk("rst_flags", i, {29'd0, cf[i], of[i], zf[i]}, 32'd0);
        pending[i] = 1'b0;
        seen[i] = 1'b0;
      end else if (!pending[i]) begin
        chk("idle_in_ready", i, 32'(rdy[i]), 32'd1);
        chk("idle_out_valid", i, 32'(vld[i]), 32'd0);
        if (in_valid) begin
          pending[i] = 1'b1;
          wcnt[i] = 0;
        end
      end else if (!vld[i]) begin
        chk("busy_in_ready", i, 32'(rdy[i]), 32'd0);
        wcnt[i]++;
      end else begin
        if (!seen[i]) begin
          chk("latency", i, 32'(wcnt[i]), 32'(lat[i]));
          seen[i] = 1'b1;
        end
        chk("result", i, res[i], expv.res);
        chk("carryout", i, 32'(cf[i]), 32'(expv.c));
        chk("overflow", i, 32'(of[i]), 32'(expv.o));
        chk("zero", i, 32'(zf[i]), 32'(expv.z));
        chk("done_in_ready", i, 32'(rdy[i]), 32'd0);
        if (out_ready) begin
          pending[i] = 1'b0;
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    expv = model(c, a, b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    command = c;
    operandA = a;
    operandB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (pending == 3'b000) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_idle: got pending %b expected 000 after 200 cycles", pending);
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'd5, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 32'hFFFF0000, 32'hFF00FF00, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd2, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 32'hFFFF0000, 32'hFF00FF00, 32'hFFFFFF00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3'd0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    operandA = '0;
    operandB = '0;
    command = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[v]) begin
      e = model(vecs[v].cmd, vecs[v].a, vecs[v].b);
      chk("model_result", v, e.res, vecs[v].res);
      chk("model_flags", v, {29'd0, e.c, e.o, e.z}, {29'd0, vecs[v].c, vecs[v].o, vecs[v].z});
      issue(vecs[v].cmd, vecs[v].a, vecs[v].b);
      wait_idle();
    end

    // Backpressure: hold results in DONE while a stray offer must be ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(vecs[0].cmd, vecs[0].a, vecs[0].b);
    operandA = 32'h0F0F0F0F;
    operandB = 32'h00FF00FF;
    command = 3'd2;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      in_valid = (c == 10);
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset while slice 2 is in flight; nothing may complete afterwards.
    issue(vecs[13].cmd, vecs[13].a, vecs[13].b);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);

    issue(vecs[12].cmd, vecs[12].a, vecs[12].b);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
